julia_iteration_sequencer: RTL and testbench

//  Drives the combinational pixel_calculator step (z' = z^2 + c, Q(INTEGRAL).(FRACTIONAL)):

---
 rtl/julia_pkg.sv | 20 ++
 rtl/pixel_calculator.sv | 36 +++
 rtl/julia_iteration_sequencer.sv | 134 +++++++++++++
 tb/tb_julia_iteration_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia iteration sequencer and its pixel step.
package julia_pkg;

  localparam int unsigned WIDTH_DEF      = 20;
  localparam int unsigned FRACTIONAL_DEF = 10;
  localparam int unsigned INTEGRAL_DEF   = 10;

  typedef enum logic [1:0] {IDLE, ITER, DONE} seq_state_t;

  // 8-bit iteration counter, wide enough for MAX_ITER up to 255
  typedef logic [7:0] iter_t;

  function automatic int escape_sq(int unsigned frac);
    return 4 << frac;
  endfunction

  // |z|^2 escape limit of 4.0 at the default fraction width
  localparam int ESCAPE_SQ = escape_sq(FRACTIONAL_DEF);

endpackage

// File: rtl/pixel_calculator.sv
// One combinational Julia step: z' = z^2 + c, |z'|^2 and iteration+1, all two's-complement wrapping.
module pixel_calculator
  import julia_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned FRACTIONAL = FRACTIONAL_DEF
) (
  input  logic signed [WIDTH-1:0] z_real_in,
  input  logic signed [WIDTH-1:0] z_imag_in,
  input  logic signed [WIDTH-1:0] c_real_in,
  input  logic signed [WIDTH-1:0] c_imag_in,
  input  iter_t                   iteration_in,
  output logic signed [WIDTH-1:0] z_real_out,
  output logic signed [WIDTH-1:0] z_imag_out,
  output logic signed [WIDTH-1:0] size_squared_out,
  output iter_t                   iteration_out
);

  localparam int unsigned PW = 2 * WIDTH + 1;

  logic signed [PW-1:0] rr, ii, ri, nrr, nii;

  always_comb begin
    // Each product is floored back to the fixed-point grid before summing
    rr = (PW'(z_real_in) * PW'(z_real_in)) >>> FRACTIONAL;
    ii = (PW'(z_imag_in) * PW'(z_imag_in)) >>> FRACTIONAL;
    ri = (PW'(z_real_in) * PW'(z_imag_in)) >>> (FRACTIONAL - 1);
    z_real_out = WIDTH'(rr - ii + PW'(c_real_in));
    z_imag_out = WIDTH'(ri + PW'(c_imag_in));
    nrr = (PW'(z_real_out) * PW'(z_real_out)) >>> FRACTIONAL;
    nii = (PW'(z_imag_out) * PW'(z_imag_out)) >>> FRACTIONAL;
    size_squared_out = WIDTH'(nrr + nii);
    iteration_out    = iteration_in + iter_t'(1);
  end

endmodule

// File: rtl/julia_iteration_sequencer.sv
// Iterates pixel_calculator on one (z0, c) job until escape or MAX_ITER; result on valid/ready.
// Optional JULIA_PERF_COUNT_EN adds a saturating count of ITER cycles on perf_iter_count.
module julia_iteration_sequencer
  import julia_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned FRACTIONAL = FRACTIONAL_DEF,
  parameter int unsigned INTEGRAL   = INTEGRAL_DEF,
  parameter int unsigned MAX_ITER   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic signed [WIDTH-1:0] job_z_real,
  input  logic signed [WIDTH-1:0] job_z_imag,
  input  logic signed [WIDTH-1:0] job_c_real,
  input  logic signed [WIDTH-1:0] job_c_imag,
  output logic                    res_valid,
  input  logic                    res_ready,
  output iter_t                   res_iter,
  output logic                    res_escaped,
  output logic signed [WIDTH-1:0] res_z_real,
  output logic signed [WIDTH-1:0] res_z_imag
`ifdef JULIA_PERF_COUNT_EN
  ,
  output logic [31:0]             perf_iter_count
`endif
);

  if (MAX_ITER == 0 || MAX_ITER > 255 || WIDTH != FRACTIONAL + INTEGRAL) begin : g_bad_cfg
    $error("julia_iteration_sequencer: illegal MAX_ITER or WIDTH/FRACTIONAL/INTEGRAL");
  end

  localparam logic signed [WIDTH-1:0] EscLim = WIDTH'(escape_sq(FRACTIONAL));

  seq_state_t state_q, state_d;
  logic signed [WIDTH-1:0] z_real_q, z_imag_q, c_real_q, c_imag_q;
  iter_t iter_q;

  logic signed [WIDTH-1:0] z_real_nx, z_imag_nx, size_nx;
  iter_t iter_nx;
  logic  escape, limit, finish;

  pixel_calculator #(
    .WIDTH     (WIDTH),
    .FRACTIONAL(FRACTIONAL)
  ) u_calc (
    .z_real_in       (z_real_q),
    .z_imag_in       (z_imag_q),
    .c_real_in       (c_real_q),
    .c_imag_in       (c_imag_q),
    .iteration_in    (iter_q),
    .z_real_out      (z_real_nx),
    .z_imag_out      (z_imag_nx),
    .size_squared_out(size_nx),
    .iteration_out   (iter_nx)
  );

  // A negative size means the squared magnitude wrapped, which is certainly an escape
  assign escape = size_nx[WIDTH-1] || (size_nx > EscLim);
  assign limit  = (iter_nx == iter_t'(MAX_ITER));
  assign finish = escape || limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (job_valid) state_d = ITER;
      ITER:    if (finish) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    job_ready = (state_q == IDLE);
    res_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_real_q    <= '0;
      z_imag_q    <= '0;
      c_real_q    <= '0;
      c_imag_q    <= '0;
      iter_q      <= '0;
      res_iter    <= '0;
      res_escaped <= 1'b0;
      res_z_real  <= '0;
      res_z_imag  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (job_valid) begin
            z_real_q <= job_z_real;
            z_imag_q <= job_z_imag;
            c_real_q <= job_c_real;
            c_imag_q <= job_c_imag;
            iter_q   <= '0;
          end
        end
        ITER: begin
          if (finish) begin
            res_iter    <= iter_nx;
            res_escaped <= escape;
            res_z_real  <= z_real_nx;
            res_z_imag  <= z_imag_nx;
          end else begin
            z_real_q <= z_real_nx;
            z_imag_q <= z_imag_nx;
            iter_q   <= iter_nx;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef JULIA_PERF_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_iter_count <= '0;
    end else if (state_q == ITER && perf_iter_count != 32'hFFFF_FFFF) begin
      perf_iter_count <= perf_iter_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_julia_iteration_sequencer.sv
// Scoreboard bench for julia_iteration_sequencer; define JULIA_PERF_COUNT_EN to also check the counter.
module tb_julia_iteration_sequencer;

  localparam int W    = 20;
  localparam int F    = 10;
  localparam int MAXI = 8;

  logic tb_clk = 1'b0;
  logic rst;
  logic job_valid, job_ready, res_valid, res_ready, res_escaped;
  logic signed [W-1:0] job_z_real, job_z_imag, job_c_real, job_c_imag;
  logic signed [W-1:0] res_z_real, res_z_imag;
  logic [7:0] res_iter;
`ifdef JULIA_PERF_COUNT_EN
  logic [31:0] perf_iter_count;
`endif

  always #5 tb_clk = ~tb_clk;

  julia_iteration_sequencer #(
    .WIDTH     (W),
    .FRACTIONAL(F),
    .INTEGRAL  (W - F),
    .MAX_ITER  (MAXI)
  ) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_z_real (job_z_real),
    .job_z_imag (job_z_imag),
    .job_c_real (job_c_real),
    .job_c_imag (job_c_imag),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_iter   (res_iter),
    .res_escaped(res_escaped),
    .res_z_real (res_z_real),
    .res_z_imag (res_z_imag)
`ifdef JULIA_PERF_COUNT_EN
    ,
    .perf_iter_count(perf_iter_count)
`endif
  );

  typedef struct {
    int     iter;
    bit     esc;
    longint zr;
    longint zi;
  } res_t;

  res_t   exp_q[$];
  int     acc_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     cyc = 0;
  longint perf_model = 0;
  bit     rr_random = 1'b0;
  bit     rr_force = 1'b1;

  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint wrap(input longint v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return longint'(t);
  endfunction

  // Reference: iterate z = z^2 + c on integers with floored fixed-point products
  function automatic res_t model(input longint zr0, input longint zi0, input longint cr,
                                 input longint ci);
    res_t r;
    longint zr, zi, nr, ni, sz;
    zr = zr0;
    zi = zi0;
    r  = '{MAXI, 1'b0, 0, 0};
    for (int i = 1; i <= MAXI; i++) begin
      nr = wrap(((zr * zr) >>> F) - ((zi * zi) >>> F) + cr);
      ni = wrap(((2 * zr * zi) >>> F) + ci);
      sz = wrap(((nr * nr) >>> F) + ((ni * ni) >>> F));
      zr = nr;
      zi = ni;
      if (sz > 4 * (1 << F) || sz < 0) begin
        r = '{i, 1'b1, zr, zi};
        return r;
      end
      if (i == MAXI) begin
        r = '{i, 1'b0, zr, zi};
        return r;
      end
    end
    return r;
  endfunction

  task automatic issue(input longint zr, input longint zi, input longint cr, input longint ci);
    res_t e;
    int   t;
    @(negedge tb_clk);
    job_z_real = zr[W-1:0];
    job_z_imag = zi[W-1:0];
    job_c_real = cr[W-1:0];
    job_c_imag = ci[W-1:0];
    job_valid  = 1'b1;
    e = model(zr, zi, cr, ci);
    exp_q.push_back(e);
    perf_model += e.iter;
    t = 0;
    #1;
    while (!job_ready && t < 200) begin
      @(negedge tb_clk);
      #1;
      t++;
    end
    if (!job_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL job_accept_timeout: job_ready stayed %0b, expected 1", job_ready);
    end
    @(posedge tb_clk);
    #1;
    // Garbage on the job bus must be ignored while busy
    job_valid  = 1'b0;
    job_z_real = W'($urandom);
    job_z_imag = W'($urandom);
    job_c_real = W'($urandom);
    job_c_imag = W'($urandom);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge tb_clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0", name, exp_q.size());
    end
    @(negedge tb_clk);
  endtask

  // res_ready driver
  initial begin
    res_ready = 1'b1;
    forever begin
      @(negedge tb_clk);
      res_ready = rr_random ? ($urandom_range(0, 3) != 0) : rr_force;
    end
  end

  // Monitor: records acceptance cycles, compares every presented result against the queue head
  initial begin : monitor
    bit   prev_v;
    int   a;
    res_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge tb_clk);
      #2;
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (job_valid && job_ready) acc_q.push_back(cyc + 1);
        if (res_valid) begin
          chk("job_ready_in_done", job_ready, 0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: res_iter=%0d with empty scoreboard", res_iter);
          end else begin
            e = exp_q[0];
            if (!prev_v) begin
              a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
              chk("latency", cyc - a, e.iter);
            end
            chk("res_iter", res_iter, e.iter);
            chk("res_escaped", res_escaped, e.esc);
            chk("res_z_real", res_z_real, e.zr);
            chk("res_z_imag", res_z_imag, e.zi);
            if (res_ready) void'(exp_q.pop_front());
          end
        end
        prev_v = res_valid;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    longint v[4];
    logic signed [W-1:0] r;
    rst        = 1'b1;
    job_valid  = 1'b0;
    job_z_real = '0;
    job_z_imag = '0;
    job_c_real = '0;
    job_c_imag = '0;
    repeat (3) @(negedge tb_clk);
    rst = 1'b0;
    #1;
    chk("reset_job_ready", job_ready, 1);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_iter", res_iter, 0);
    chk("reset_res_z_real", res_z_real, 0);
    chk("reset_res_escaped", res_escaped, 0);

    // T1, T2, T3 directed
    issue(1024, 512, -512, 512);
    drain("t1");
    issue(0, 0, 0, 0);
    drain("t2");
`ifdef JULIA_PERF_COUNT_EN
    chk("t6_perf_count", perf_iter_count, 10);
`endif
    issue(0, 0, 2048, 0);
    drain("t3");

    // T4 backpressure
    rr_random = 1'b0;
    rr_force  = 1'b0;
    issue(1024, 512, -512, 512);
    t = 0;
    while (!res_valid && t < 100) begin
      @(negedge tb_clk);
      #3;
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge tb_clk);
      #3;
      chk("t4_res_valid_held", res_valid, 1);
      chk("t4_job_ready_low", job_ready, 0);
      chk("t4_res_z_real_held", res_z_real, -2752);
    end
    rr_force = 1'b1;
    @(negedge tb_clk);
    #3;
    @(negedge tb_clk);
    #3;
    chk("t4_res_valid_dropped", res_valid, 0);
    chk("t4_job_ready_back", job_ready, 1);
    drain("t4");

    // T5 async reset during ITER
    issue(0, 0, 0, 0);
    repeat (3) @(posedge tb_clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_res_valid", res_valid, 0);
    chk("t5_res_iter", res_iter, 0);
    chk("t5_res_escaped", res_escaped, 0);
    chk("t5_res_z_real", res_z_real, 0);
    chk("t5_res_z_imag", res_z_imag, 0);
    exp_q.delete();
    acc_q.delete();
    perf_model = 0;
    repeat (2) @(negedge tb_clk);
    rst = 1'b0;
    #1;
    chk("t5_job_ready", job_ready, 1);
    issue(1024, 512, -512, 512);
    drain("t5");

    // Random jobs, mostly within +/-2.0, some full-range to exercise wrapping
    rr_random = 1'b1;
    for (int j = 0; j < 40; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (j % 8 == 7) begin
          r = W'($urandom);
          v[k] = longint'(r);
        end else begin
          v[k] = longint'($urandom_range(0, 4096)) - 2048;
        end
      end
      issue(v[0], v[1], v[2], v[3]);
    end
    drain("random");
    rr_random = 1'b0;
`ifdef JULIA_PERF_COUNT_EN
    chk("perf_count_final", perf_iter_count, perf_model);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
